// File: rtl/gig_eth_rx_frame_fifo.sv
// rtl/gig_eth_rx_frame_fifo.sv - store-and-forward RX frame FIFO
// Only good, complete frames become visible on m_axis; bad/overflowed frames roll back.
module gig_eth_rx_frame_fifo #(
    parameter int ADDR_WIDTH = 12
) (
    input  logic        rx_clk,
    input  logic        reset,
    input  logic [7:0]  s_axis_tdata,
    input  logic        s_axis_tvalid,
    input  logic        s_axis_tlast,
    input  logic        s_axis_tuser,
    output logic [7:0]  m_axis_tdata,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        m_axis_tlast,
    output logic [31:0] stat_good_frames,
    output logic [31:0] stat_bad_frames,
    output logic [31:0] stat_ovf_frames
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] C_DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

    typedef enum logic [1:0] {WR_IDLE, WR_FRAME, WR_DROP} wr_state_t;

    logic [8:0]          r_mem [DEPTH];
    logic [ADDR_WIDTH:0] r_wr_ptr;
    logic [ADDR_WIDTH:0] r_commit_ptr;
    logic [ADDR_WIDTH:0] r_rd_ptr;
    wr_state_t           r_wr_state;
    logic [7:0]          r_m_tdata;
    logic                r_m_tvalid;
    logic                r_m_tlast;
    logic [31:0]         r_good;
    logic [31:0]         r_bad;
    logic [31:0]         r_ovf;

    logic [ADDR_WIDTH:0] w_used;
    logic                w_full;
    logic                w_wr_en;
    logic                w_rd_load;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    // Full is conservative: it ignores a read happening in the same cycle,
    // so a freed slot becomes writable one cycle after the read.
    assign w_used  = r_wr_ptr - r_rd_ptr;
    assign w_full  = (w_used == C_DEPTH);
    assign w_wr_en = s_axis_tvalid && !w_full && (r_wr_state != WR_DROP)
                     && !(s_axis_tlast && s_axis_tuser);

    always_ff @(posedge rx_clk) begin
        if (w_wr_en)
            r_mem[r_wr_ptr[ADDR_WIDTH-1:0]] <= {s_axis_tlast, s_axis_tdata};
    end

    always_ff @(posedge rx_clk or posedge reset) begin
        if (reset) begin
            r_wr_state   <= WR_IDLE;
            r_wr_ptr     <= '0;
            r_commit_ptr <= '0;
            r_good       <= '0;
            r_bad        <= '0;
            r_ovf        <= '0;
        end else if (s_axis_tvalid) begin
            case (r_wr_state)
                WR_IDLE, WR_FRAME: begin
                    if (w_full) begin
                        r_wr_ptr <= r_commit_ptr;
                        if (s_axis_tlast) begin
                            r_ovf      <= sat_inc(r_ovf);
                            r_wr_state <= WR_IDLE;
                        end else begin
                            r_wr_state <= WR_DROP;
                        end
                    end else if (!s_axis_tlast) begin
                        r_wr_ptr   <= r_wr_ptr + 1'b1;
                        r_wr_state <= WR_FRAME;
                    end else if (!s_axis_tuser) begin
                        r_wr_ptr     <= r_wr_ptr + 1'b1;
                        r_commit_ptr <= r_wr_ptr + 1'b1;
                        r_good       <= sat_inc(r_good);
                        r_wr_state   <= WR_IDLE;
                    end else begin
                        r_wr_ptr   <= r_commit_ptr;
                        r_bad      <= sat_inc(r_bad);
                        r_wr_state <= WR_IDLE;
                    end
                end
                WR_DROP: begin
                    if (s_axis_tlast) begin
                        r_ovf      <= sat_inc(r_ovf);
                        r_wr_state <= WR_IDLE;
                    end
                end
                default: r_wr_state <= WR_IDLE;
            endcase
        end
    end

    // Output register is refilled whenever it is empty or being consumed.
    assign w_rd_load = (r_rd_ptr != r_commit_ptr) && (!r_m_tvalid || m_axis_tready);

    always_ff @(posedge rx_clk or posedge reset) begin
        if (reset) begin
            r_rd_ptr   <= '0;
            r_m_tdata  <= '0;
            r_m_tlast  <= 1'b0;
            r_m_tvalid <= 1'b0;
        end else if (w_rd_load) begin
            {r_m_tlast, r_m_tdata} <= r_mem[r_rd_ptr[ADDR_WIDTH-1:0]];
            r_m_tvalid             <= 1'b1;
            r_rd_ptr               <= r_rd_ptr + 1'b1;
        end else if (m_axis_tready) begin
            r_m_tvalid <= 1'b0;
        end
    end

    assign m_axis_tdata     = r_m_tdata;
    assign m_axis_tvalid    = r_m_tvalid;
    assign m_axis_tlast     = r_m_tlast;
    assign stat_good_frames = r_good;
    assign stat_bad_frames  = r_bad;
    assign stat_ovf_frames  = r_ovf;
endmodule

// File: doc/gig_eth_rx_frame_fifo.md
GIG_ETH_RX_FRAME_FIFO -- requirements
Module: gig_eth_rx_frame_fifo

Interface
REQ-001 Parameter ADDR_WIDTH, default 12; the buffer holds 2^ADDR_WIDTH bytes (DEPTH).
REQ-002 reset  input  1  asynchronous, active-high.
REQ-003 rx_clk  input  1  clock for all logic; there is only one clock domain.
REQ-004 s_axis_tdata  input  8  byte from the RX MAC.
REQ-005 s_axis_tvalid  input  1  byte valid; there is no backpressure (no s_axis_tready).
REQ-006 s_axis_tlast  input  1  last byte of frame; sampled only when s_axis_tvalid=1.
REQ-007 s_axis_tuser  input  1  frame bad, qualified by tvalid&tlast.
REQ-008 m_axis_tdata  output  8  byte to the client.
REQ-009 m_axis_tvalid  output  1  committed byte available.
REQ-010 m_axis_tready  input  1  client accepts; transfer = tvalid&tready.
REQ-011 m_axis_tlast  output  1  last byte of a committed frame.
REQ-012 stat_good_frames, stat_bad_frames, stat_ovf_frames  output  32 each  saturating counts.

Function
REQ-013 Store-and-forward: only complete frames that end tlast=1, tuser=0 and do not overflow are output; no byte of any other frame appears on m_axis.
REQ-014 Storage is DEPTH x 9 bits, holding {tlast, tdata}; the write and read pointers are ADDR_WIDTH+1 bits wide and wrap modulo 2^(ADDR_WIDTH+1).
REQ-015 Pointers: wr_ptr (speculative write), commit_ptr (end of the last good frame), rd_ptr (read); the buffer is full when wr_ptr-rd_ptr == DEPTH.
REQ-016 Write FSM states: WR_IDLE, WR_FRAME, WR_DROP.
REQ-017 WR_IDLE or WR_FRAME, tvalid=1, not full, tlast=0: write the byte, wr_ptr+1, go to WR_FRAME.
REQ-018 WR_IDLE or WR_FRAME, tvalid=1, not full, tlast=1, tuser=0: write the byte, commit_ptr <= wr_ptr+1, stat_good_frames+1, go to WR_IDLE; a 1-byte frame is legal.
REQ-019 WR_IDLE or WR_FRAME, tvalid=1, not full, tlast=1, tuser=1: no write, wr_ptr <= commit_ptr, stat_bad_frames+1, go to WR_IDLE.
REQ-020 WR_IDLE or WR_FRAME, tvalid=1, full, tlast=0: wr_ptr <= commit_ptr, go to WR_DROP.
REQ-021 WR_IDLE or WR_FRAME, tvalid=1, full, tlast=1: wr_ptr <= commit_ptr, stat_ovf_frames+1, go to WR_IDLE.
REQ-022 WR_DROP: discard all bytes; on tvalid&tlast, stat_ovf_frames+1 regardless of tuser, go to WR_IDLE.
REQ-023 A frame is counted in exactly one counter; all counters saturate at 32'hFFFFFFFF.
REQ-024 tvalid=0 in any state: no state change; gaps inside a frame are tolerated.
REQ-025 Read side: m_axis_tvalid=1 iff a byte at an address below commit_ptr is presented; the read side never uses wr_ptr.
REQ-026 m_axis_tvalid asserts within 2 rx_clk cycles after the commit edge when the buffer was previously empty.
REQ-027 With tready held at 1, the read side sustains 1 byte per cycle, with no bubble between or inside frames.
REQ-028 m_axis_tdata and m_axis_tlast stay stable while tvalid=1 and tready=0.
REQ-029 A read and a write/commit/rollback in the same cycle are all honoured; rollback never moves wr_ptr below commit_ptr.
REQ-030 Full is evaluated against rd_ptr including a read in the same cycle, or conservatively without it; the choice must be consistent and documented in the RTL.

Reset
REQ-031 On reset, all pointers are 0, the FSM is in WR_IDLE, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, and all counters are 0.
REQ-032 Reset mid-frame or mid-read discards all buffered data; the first complete frame after reset release is handled normally.

Verification (ADDR_WIDTH=6, DEPTH=64)
REQ-033 64-byte good frame 00..3F, tready=1 -> bytes 00..3F out in order, tlast only on 3F, good=1; first m_axis_tvalid at most 2 cycles after the input tlast.
REQ-034 20-byte frame with tuser=1 on tlast, then a 10-byte good frame -> only the 10 bytes are output, bad=1, good=1.
REQ-035 tready=0, a 40-byte good frame, then a 30-byte frame -> the second frame goes to WR_DROP at byte 25, ovf=1; after tready=1 only the 40 bytes are output.
REQ-036 1-byte good frame, 0xA5 -> one transfer, tdata=A5, tlast=1, good=1.
REQ-037 Random tready with 1000 good frames of lengths 1..64 crossing the pointer wrap -> scoreboard matches exactly, good=1000, and m_axis_tdata is stable while stalled.
REQ-038 Reset asserted at byte 10 of a 30-byte frame -> m_axis_tvalid=0 and counters=0; the next 5-byte frame is output correctly.
